// File: rtl/id_ex_stage_pkg.sv
// Shared decode/execute definitions: ALU operation codes, operand-select
// encodings and the held control bundle of the ID/EX pipeline register.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] SRC1_RS1  = 2'd0;
  localparam logic [1:0] SRC1_PC   = 2'd1;
  localparam logic [1:0] SRC1_ZERO = 2'd2;

  localparam logic [1:0] SRC2_RS2  = 2'd0;
  localparam logic [1:0] SRC2_IMM  = 2'd1;
  localparam logic [1:0] SRC2_FOUR = 2'd2;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] src1_sel;
    logic [1:0] src2_sel;
    logic [4:0] rd_addr;
    logic       rd_we;
  } ctrl_t;

  // x0 is hard-wired, so a write-back to it never forwards.
  function automatic logic wb_hit(input logic       we,
                                  input logic [4:0] wb_addr,
                                  input logic [4:0] rs_addr);
    return we && (wb_addr != 5'd0) && (wb_addr == rs_addr);
  endfunction

endpackage

// File: rtl/id_ex_stage_operand_slot.sv
// One held source operand: captures with write-back bypass and x0 forcing,
// then optionally keeps snooping the write-back bus while the stage stalls.
module id_ex_stage_operand_slot
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit SNOOP_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic            hold,
  input  logic [4:0]      id_addr,
  input  logic [XLEN-1:0] id_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] value
);

  logic [4:0]      addr_r;
  logic [XLEN-1:0] data_r;
  logic [XLEN-1:0] cap_data_s;
  logic            snoop_s;

  // Value to register on capture: x0 first, then the same-cycle write-back.
  always_comb begin
    cap_data_s = id_data;
    if (id_addr == 5'd0) begin
      cap_data_s = '0;
    end else if (wb_hit(wb_we, wb_addr, id_addr)) begin
      cap_data_s = wb_data;
    end else begin
      cap_data_s = id_data;
    end
  end

  assign snoop_s = SNOOP_EN && hold && wb_hit(wb_we, wb_addr, addr_r);

  // Operand register: capture, stall-time snoop, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= 5'd0;
      data_r <= '0;
    end else if (capture) begin
      addr_r <= id_addr;
      data_r <= cap_data_s;
    end else if (snoop_s) begin
      data_r <= wb_data;
    end
  end

  assign value = data_r;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: valid/ready handshake with flush, held control
// fields and operands, and the ALU operand-select muxes.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit SNOOP_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_op,
  input  logic [1:0]      id_src1_sel,
  input  logic [1:0]      id_src2_sel,
  input  logic [4:0]      id_rd_addr,
  input  logic            id_rd_we,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] src1,
  output logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_rd_we
);

  logic            ex_valid_r;
  ctrl_t           ctrl_r;
  ctrl_t           id_ctrl_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] imm_r;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic            capture_s;
  logic            hold_s;

  // id_ready depends only on registered state and ex_ready, never on id_valid.
  assign id_ready  = !ex_valid_r || ex_ready;
  assign capture_s = id_valid && id_ready && !flush;
  assign hold_s    = ex_valid_r && !ex_ready;

  assign id_ctrl_s = '{alu_op:   id_alu_op,
                       src1_sel: id_src1_sel,
                       src2_sel: id_src2_sel,
                       rd_addr:  id_rd_addr,
                       rd_we:    id_rd_we};

  // Occupancy: flush wins, then capture, then drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r <= 1'b0;
    end else if (flush) begin
      ex_valid_r <= 1'b0;
    end else if (capture_s) begin
      ex_valid_r <= 1'b1;
    end else if (ex_ready) begin
      ex_valid_r <= 1'b0;
    end
  end

  // Control fields, PC and immediate load only on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r <= '0;
      pc_r   <= '0;
      imm_r  <= '0;
    end else if (capture_s) begin
      ctrl_r <= id_ctrl_s;
      pc_r   <= id_pc;
      imm_r  <= id_imm;
    end
  end

  id_ex_stage_operand_slot #(.XLEN(XLEN), .SNOOP_EN(SNOOP_EN)) u_rs1 (
    .clk     (clk),
    .rst     (rst),
    .capture (capture_s),
    .hold    (hold_s),
    .id_addr (id_rs1_addr),
    .id_data (id_rs1_data),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .value   (rs1_val_s)
  );

  id_ex_stage_operand_slot #(.XLEN(XLEN), .SNOOP_EN(SNOOP_EN)) u_rs2 (
    .clk     (clk),
    .rst     (rst),
    .capture (capture_s),
    .hold    (hold_s),
    .id_addr (id_rs2_addr),
    .id_data (id_rs2_data),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .value   (rs2_val_s)
  );

  // Operand-select muxes; reserved encodings give zero.
  always_comb begin
    src1 = '0;
    src2 = '0;
    case (ctrl_r.src1_sel)
      SRC1_RS1:  src1 = rs1_val_s;
      SRC1_PC:   src1 = pc_r;
      SRC1_ZERO: src1 = '0;
      default:   src1 = '0;
    endcase
    case (ctrl_r.src2_sel)
      SRC2_RS2:  src2 = rs2_val_s;
      SRC2_IMM:  src2 = imm_r;
      SRC2_FOUR: src2 = XLEN'(4);
      default:   src2 = '0;
    endcase
  end

  assign ex_valid   = ex_valid_r;
  assign alu_op     = ctrl_r.alu_op;
  assign ex_pc      = pc_r;
  assign ex_rd_addr = ctrl_r.rd_addr;
  assign ex_rd_we   = ctrl_r.rd_we && ex_valid_r && (ctrl_r.rd_addr != 5'd0);

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the held instruction.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            id_valid = 1'b0;
  logic            id_ready;
  logic [XLEN-1:0] id_pc = '0;
  logic [4:0]      id_rs1_addr = 5'd0;
  logic [4:0]      id_rs2_addr = 5'd0;
  logic [XLEN-1:0] id_rs1_data = '0;
  logic [XLEN-1:0] id_rs2_data = '0;
  logic [XLEN-1:0] id_imm = '0;
  logic [3:0]      id_alu_op = 4'd0;
  logic [1:0]      id_src1_sel = 2'd0;
  logic [1:0]      id_src2_sel = 2'd0;
  logic [4:0]      id_rd_addr = 5'd0;
  logic            id_rd_we = 1'b0;
  logic            flush = 1'b0;
  logic            wb_we = 1'b0;
  logic [4:0]      wb_addr = 5'd0;
  logic [XLEN-1:0] wb_data = '0;
  logic            ex_valid;
  logic            ex_ready = 1'b0;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rd_addr;
  logic            ex_rd_we;

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction the stage should be holding.
  logic            m_valid = 1'b0;
  logic [XLEN-1:0] m_pc = '0, m_imm = '0, m_rs1 = '0, m_rs2 = '0;
  logic [4:0]      m_rs1_a = 5'd0, m_rs2_a = 5'd0, m_rd = 5'd0;
  logic [3:0]      m_op = 4'd0;
  logic [1:0]      m_s1 = 2'd0, m_s2 = 2'd0;
  logic            m_we = 1'b0;

  id_ex_stage #(.XLEN(XLEN), .SNOOP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_op(alu_op),
    .src1(src1), .src2(src2), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .ex_rd_we(ex_rd_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic fwd(input logic [4:0] a);
    return wb_we && (wb_addr != 5'd0) && (wb_addr == a);
  endfunction

  function automatic logic [XLEN-1:0] cap_val(input logic [4:0] a, input logic [XLEN-1:0] d);
    if (a == 5'd0) return '0;
    if (fwd(a)) return wb_data;
    return d;
  endfunction

  function automatic logic [XLEN-1:0] exp_src1();
    if (m_s1 == 2'd0) return m_rs1;
    if (m_s1 == 2'd1) return m_pc;
    return '0;
  endfunction

  function automatic logic [XLEN-1:0] exp_src2();
    if (m_s2 == 2'd0) return m_rs2;
    if (m_s2 == 2'd1) return m_imm;
    if (m_s2 == 2'd2) return 32'd4;
    return '0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0;
    m_rs1_a = 5'd0; m_rs2_a = 5'd0; m_rd = 5'd0; m_op = 4'd0;
    m_s1 = 2'd0; m_s2 = 2'd0; m_we = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":ex_valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ":ex_rd_we"}, 32'(ex_rd_we), 32'(m_valid && m_we && (m_rd != 5'd0)));
    if (m_valid) begin
      chk({tag, ":alu_op"}, 32'(alu_op), 32'(m_op));
      chk({tag, ":src1"}, src1, exp_src1());
      chk({tag, ":src2"}, src2, exp_src2());
      chk({tag, ":ex_pc"}, ex_pc, m_pc);
      chk({tag, ":ex_rd_addr"}, 32'(ex_rd_addr), 32'(m_rd));
    end
  endtask

  // One clock: check id_ready, predict the next held state, clock, compare.
  task automatic cycle(input string tag);
    logic take;
    logic n_valid;
    logic [XLEN-1:0] n_rs1, n_rs2;
    #1;
    chk({tag, ":id_ready"}, 32'(id_ready), 32'(!m_valid || ex_ready));
    take    = id_valid && (!m_valid || ex_ready) && !flush;
    n_valid = m_valid;
    n_rs1   = m_rs1;
    n_rs2   = m_rs2;
    if (!rst && !flush && !take && m_valid && !ex_ready) begin
      if (fwd(m_rs1_a)) n_rs1 = wb_data;
      if (fwd(m_rs2_a)) n_rs2 = wb_data;
    end
    if (take) begin
      n_rs1 = cap_val(id_rs1_addr, id_rs1_data);
      n_rs2 = cap_val(id_rs2_addr, id_rs2_data);
    end
    if (flush) n_valid = 1'b0;
    else if (take) n_valid = 1'b1;
    else if (ex_ready) n_valid = 1'b0;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (take) begin
        m_pc = id_pc; m_imm = id_imm; m_rs1_a = id_rs1_addr; m_rs2_a = id_rs2_addr;
        m_op = id_alu_op; m_s1 = id_src1_sel; m_s2 = id_src2_sel;
        m_rd = id_rd_addr; m_we = id_rd_we;
      end
      m_valid = n_valid; m_rs1 = n_rs1; m_rs2 = n_rs2;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic offer(input logic [4:0] a1, input logic [XLEN-1:0] d1,
                       input logic [4:0] a2, input logic [XLEN-1:0] d2,
                       input logic [1:0] s1, input logic [1:0] s2,
                       input logic [3:0] op, input logic [4:0] rd);
    id_valid = 1'b1; id_rs1_addr = a1; id_rs1_data = d1; id_rs2_addr = a2;
    id_rs2_data = d2; id_src1_sel = s1; id_src2_sel = s2; id_alu_op = op;
    id_rd_addr = rd; id_rd_we = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst:ex_valid", 32'(ex_valid), 32'd0);
    chk("rst:alu_op", 32'(alu_op), 32'(ALU_ADD));
    chk("rst:src1", src1, 32'd0);
    chk("rst:src2", src2, 32'd0);
    chk("rst:ex_rd_we", 32'(ex_rd_we), 32'd0);
    rst = 1'b0;

    // Load, stall, then asynchronous reset mid-stall
    offer(5'd3, 32'h55, 5'd4, 32'h66, SRC1_RS1, SRC2_RS2, ALU_SUB, 5'd7);
    ex_ready = 1'b1;
    cycle("load");
    id_valid = 1'b0; ex_ready = 1'b0;
    cycle("stall0");
    #2; rst = 1'b1; #1;
    chk("arst:ex_valid", 32'(ex_valid), 32'd0);
    chk("arst:src1", src1, 32'd0);
    chk("arst:src2", src2, 32'd0);
    chk("arst:ex_rd_we", 32'(ex_rd_we), 32'd0);
    model_reset();
    cycle("arst_hold");
    rst = 1'b0;
    cycle("arst_rel1");
    cycle("arst_rel2");
    chk("arst_rel:src1", src1, 32'd0);
    chk("arst_rel:src2", src2, 32'd0);

    // Plain ADD capture
    offer(5'd5, 32'd10, 5'd6, 32'd7, SRC1_RS1, SRC2_RS2, ALU_ADD, 5'd8);
    ex_ready = 1'b1;
    cycle("add");
    chk("add:src1", src1, 32'd10);
    chk("add:src2", src2, 32'd7);

    // Stall with snoop of rs2=x6 in the second stall cycle
    offer(5'd9, 32'hdead, 5'd10, 32'hbeef, SRC1_PC, SRC2_IMM, ALU_XOR, 5'd11);
    ex_ready = 1'b0;
    cycle("stall1");
    wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'd99;
    cycle("stall2");
    wb_we = 1'b0;
    cycle("stall3");
    chk("snoop:src2", src2, 32'd99);
    chk("snoop:src1", src1, 32'd10);

    // Capture-time bypass, then x0 with a write-back to x0
    ex_ready = 1'b1;
    offer(5'd5, 32'd0, 5'd2, 32'h22, SRC1_RS1, SRC2_RS2, ALU_OR, 5'd12);
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    cycle("bypass");
    chk("bypass:src1", src1, 32'h1234);
    offer(5'd0, 32'h777, 5'd2, 32'h22, SRC1_RS1, SRC2_RS2, ALU_OR, 5'd12);
    wb_addr = 5'd0; wb_data = 32'h4321;
    cycle("x0");
    chk("x0:src1", src1, 32'd0);
    wb_we = 1'b0;

    // JAL-style: pc + 4, rd=1 then rd=0
    offer(5'd1, 32'h1, 5'd2, 32'h2, SRC1_PC, SRC2_FOUR, ALU_ADD, 5'd1);
    id_pc = 32'h100;
    cycle("jal_rd1");
    chk("jal:src1", src1, 32'h100);
    chk("jal:src2", src2, 32'd4);
    chk("jal:rd_we1", 32'(ex_rd_we), 32'd1);
    id_rd_addr = 5'd0;
    cycle("jal_rd0");
    chk("jal:rd_we0", 32'(ex_rd_we), 32'd0);

    // Flush with the stage empty, then a normal capture
    id_valid = 1'b0;
    cycle("drain");
    offer(5'd7, 32'h70, 5'd8, 32'h80, SRC1_RS1, SRC2_RS2, ALU_AND, 5'd13);
    flush = 1'b1;
    cycle("flush");
    chk("flush:ex_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0;
    cycle("post_flush");
    chk("post_flush:ex_valid", 32'(ex_valid), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      id_valid    = 1'($urandom_range(0, 1));
      id_pc       = $urandom;
      id_imm      = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 7));
      id_rs2_addr = 5'($urandom_range(0, 7));
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_alu_op   = 4'($urandom_range(0, 15));
      id_src1_sel = 2'($urandom_range(0, 3));
      id_src2_sel = 2'($urandom_range(0, 3));
      id_rd_addr  = 5'($urandom_range(0, 3));
      id_rd_we    = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 15) == 0);
      ex_ready    = ($urandom_range(0, 2) != 0);
      wb_we       = 1'($urandom_range(0, 1));
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
